// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM lane demultiplexer with frame-marker sync tracking.
// Samples are staged per slot and published as a complete frame on A..D.
module tdm_demux4 #(
   parameter int WIDTH        = 8,
   parameter bit REQUIRE_SYNC = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic             frame_valid,
   output logic [3:0]       lane_stb,
   output logic             sel1,
   output logic             sel0,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

   state_t           state_reg;
   logic [1:0]       slot_reg;
   logic [WIDTH-1:0] stage_reg [3];

   logic             acc;
   logic [1:0]       acc_slot;
   logic             err;
   logic             go_hunt;

   // Decide what the current sample does: accept into a slot, flag an error, or both.
   always_comb begin
      acc      = 1'b0;
      acc_slot = slot_reg;
      err      = 1'b0;
      go_hunt  = 1'b0;
      if (din_valid) begin
         if (state_reg == HUNT) begin
            if (frame_sync) begin
               acc      = 1'b1;
               acc_slot = 2'd0;
            end
         end else if (frame_sync && slot_reg != 2'd0) begin
            err      = 1'b1;
            acc      = 1'b1;
            acc_slot = 2'd0;
         end else if (!frame_sync && slot_reg == 2'd0 && REQUIRE_SYNC) begin
            err     = 1'b1;
            go_hunt = 1'b1;
         end else begin
            acc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= HUNT;
         slot_reg    <= 2'd0;
         A           <= '0;
         B           <= '0;
         C           <= '0;
         D           <= '0;
         frame_valid <= 1'b0;
         lane_stb    <= 4'b0000;
         sync_err    <= 1'b0;
      end else begin
         lane_stb    <= acc ? (4'b0001 << acc_slot) : 4'b0000;
         sync_err    <= err;
         frame_valid <= acc && (acc_slot == 2'd3);
         if (acc) begin
            state_reg <= LOCK;
            slot_reg  <= acc_slot + 2'd1;
         end
         if (go_hunt) begin
            state_reg <= HUNT;
            slot_reg  <= 2'd0;
         end
         // Slot 3 completes the frame; all four lanes update on the same edge.
         if (acc && acc_slot == 2'd3) begin
            A <= stage_reg[0];
            B <= stage_reg[1];
            C <= stage_reg[2];
            D <= din;
         end
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stage_reg[gi] <= '0;
         end else if (acc && acc_slot == gi[1:0]) begin
            stage_reg[gi] <= din;
         end
      end
   end

   assign sel1   = slot_reg[1];
   assign sel0   = slot_reg[0];
   assign locked = (state_reg == LOCK);

endmodule
